// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 port arbiter: FSM encoding, port indices
// and default widths.
package l2_arb_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 11;
   localparam int DEF_BLOCK_SIZE = 32;

   // Port indices: bit 0 is the instruction cache, bit 1 the data cache.
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_L2 = 2'd2,
      ST_RESP    = 2'd3
   } arb_state_e;

   // Converts a one-hot 2-bit grant into the index of the granted port.
   function automatic logic onehot_to_idx(input logic [1:0] oh);
      return oh[1];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter. On a tie the port named by prio_i wins;
// a single requester always wins; no request gives a zero grant.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       prio_i,
   output logic [1:0] gnt_o
);

   // Resolve ties with the priority index, otherwise pass the request through.
   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
         gnt_o = prio_i ? 2'b10 : 2'b01;
      end else begin
         gnt_o = req_i;
      end
   end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates the L1I (port 0) and L1D (port 1) block requests onto a single
// shared L2 port. One transaction at a time: IDLE -> ISSUE -> WAIT_L2 -> RESP.
// Optional feature macro L2_ARB_FIXED_PRIO_EN: port 1 always wins ties and the
// round-robin pointer is removed; default build is round-robin.
//
// Handshake: a port raises p_read/p_write and it is sampled only in IDLE.
// The L2 request is held stable from ISSUE until l2_ready=1 is sampled in
// WAIT_L2; the granted port then sees a one-cycle p_ready pulse in RESP,
// whether or not it still holds its request.
module l2_port_arbiter
   import l2_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
   localparam int BW        = BLOCK_SIZE * DATA_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 p_read,
   input  logic [1:0]                 p_write,
   input  logic [1:0][ADDR_WIDTH-1:0] p_addr,
   input  logic [1:0][BW-1:0]         p_wdata,
   output logic [1:0]                 p_ready,
   output logic [1:0]                 p_valid,
   output logic [1:0]                 p_hit,
   output logic [BW-1:0]              p_rdata,
   output logic                       l2_read,
   output logic                       l2_write,
   output logic [ADDR_WIDTH-1:0]      l2_addr,
   output logic [BW-1:0]              l2_wdata,
   input  logic                       l2_ready,
   input  logic                       l2_valid,
   input  logic                       l2_hit,
   input  logic [BW-1:0]              l2_rdata,
   output logic [1:0]                 grant,
   output arb_state_e                 dbg_state_o
);

   arb_state_e            state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BW-1:0]         wdata_q, wdata_d;
   logic                  wr_q, wr_d;
   logic                  rd_q, rd_d;
   logic [BW-1:0]         rdata_q, rdata_d;
   logic                  valid_q, valid_d;
   logic                  hit_q, hit_d;

   logic [1:0] req;
   logic [1:0] arb_gnt;
   logic       win;
   logic       prio;

   assign req = p_read | p_write;
   assign win = onehot_to_idx(arb_gnt);

   rr_arbiter2 u_rr_arbiter2 (
      .req_i  (req),
      .prio_i (prio),
      .gnt_o  (arb_gnt)
   );

`ifdef L2_ARB_FIXED_PRIO_EN
   assign prio = PORT_D;
`else
   logic prio_q, prio_d;

   // After serving a port, hand tie priority to the other port.
   always_comb begin
      prio_d = prio_q;
      if (state_q == ST_RESP) begin
         prio_d = ~onehot_to_idx(grant_q);
      end
   end

   // Round-robin pointer register; port 0 has priority out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= PORT_I;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign prio = prio_q;
`endif

   // Next-state logic: latch the winner in IDLE, capture the L2 response.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;
      valid_d = valid_q;
      hit_d   = hit_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grant_d = arb_gnt;
               addr_d  = p_addr[win];
               wdata_d = p_wdata[win];
               // Read and write together counts as a write.
               wr_d    = p_write[win];
               rd_d    = ~p_write[win];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_L2;
         end
         ST_WAIT_L2: begin
            if (l2_ready) begin
               rdata_d = l2_rdata;
               valid_d = l2_valid;
               hit_d   = l2_hit;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and holding registers; reset abandons any transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
         valid_q <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         hit_q   <= hit_d;
      end
   end

   // Output decode: L2 request during ISSUE/WAIT_L2, port pulse in RESP only.
   always_comb begin
      l2_read  = 1'b0;
      l2_write = 1'b0;
      l2_addr  = '0;
      l2_wdata = '0;
      p_ready  = 2'b00;
      p_valid  = 2'b00;
      p_hit    = 2'b00;
      p_rdata  = '0;
      if (state_q == ST_ISSUE || state_q == ST_WAIT_L2) begin
         l2_read  = rd_q;
         l2_write = wr_q;
         l2_addr  = addr_q;
         l2_wdata = wdata_q;
      end
      if (state_q == ST_RESP) begin
         p_ready = grant_q;
         p_valid = grant_q & {2{valid_q}};
         p_hit   = grant_q & {2{hit_q}};
         p_rdata = rdata_q;
      end
   end

   assign grant       = grant_q;
   assign dbg_state_o = state_q;

endmodule
